// File: rtl/result_ascii_tx_if.sv
// Byte-level handshake between the ALU result side, the ASCII serializer and the UART TX.
// master drives the request and tx_done; slave is the serializer.
interface result_ascii_tx_if;
    logic       start;
    logic [7:0] data;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done_tick;

    modport master (
        output start, data, tx_done,
        input  tx_start, tx_data, busy, done_tick
    );

    modport slave (
        input  start, data, tx_done,
        output tx_start, tx_data, busy, done_tick
    );
endinterface

// File: rtl/result_ascii_tx.sv
// Sends an 8-bit result as two uppercase hex characters (plus optional CR LF) to the UART TX,
// one character per tx_start/tx_done handshake.
module result_ascii_tx #(
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    result_ascii_tx_if.slave bus
);
    localparam logic [1:0] LAST_IDX = SEND_CRLF ? 2'd3 : 2'd1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [7:0] r_result, w_result_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;

    function automatic logic [7:0] f_hex(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) c = {4'h3, nib};
        else             c = 8'h37 + {4'h0, nib};
        return c;
    endfunction

    function automatic logic [7:0] f_char(input logic [7:0] res, input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = f_hex(res[7:4]);
            2'd1:    c = f_hex(res[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_result  <= 8'd0;
            r_tx_data <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_result  <= w_result_nxt;
            r_tx_data <= w_tx_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_result_nxt  = r_result;
        w_tx_data_nxt = r_tx_data;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_result_nxt = bus.data;
                    w_idx_nxt    = 2'd0;
                    w_state_nxt  = SEND;
                end
            end
            SEND: w_state_nxt = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = SEND;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // SEND is only entered from IDLE or WAIT, so this loads the character exactly once
        if (w_state_nxt == SEND) w_tx_data_nxt = f_char(w_result_nxt, w_idx_nxt);
    end

    assign bus.tx_start  = (r_state == SEND);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done_tick = (r_state == DONE);
    assign bus.tx_data   = r_tx_data;
endmodule

// File: doc/result_ascii_tx.md
# result_ascii_tx

Converts an 8-bit ALU result into printable ASCII and hands it, one character at a time, to the UART transmitter. It is the outbound counterpart of the ASCII-to-opcode conversion path. Each result is sent as two uppercase hex digits, optionally followed by CR LF. The block sits between the ALU result register and the UART TX byte interface and paces itself on the transmitter's per-byte completion pulse.

## Interface
- SEND_CRLF, default 1: 1 appends CR (13) and LF (10) after the two hex digits (4 chars total); 0 sends the hex digits only (2 chars).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- start  input  1  request to send `data`; sampled only in IDLE.
- data  input  8  result byte; latched on the accepting edge.
- tx_done  input  1  one-cycle pulse from the UART TX when the current byte has finished.
- tx_start  output  1  one-cycle pulse: UART TX loads `tx_data`.
- tx_data  output  8  ASCII character being sent; stable from `tx_start` until the matching `tx_done`.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done_tick  output  1  one-cycle pulse after the last character's `tx_done`.

## Operation
- States:
  - IDLE: waits for `start`.
  - SEND: `tx_start`=1.
  - WAIT: waits for `tx_done`.
  - DONE: `done_tick`=1.
- All outputs are Moore and registered or decoded from registered state. No combinational path from inputs to outputs.
- Transitions:
  - IDLE with `start`=1: latch `data` into the internal result register, clear char index, go to SEND.
  - SEND: go to WAIT unconditionally.
  - WAIT with `tx_done`=1 and index < N-1: increment index, go to SEND.
  - WAIT with `tx_done`=1 and index = N-1: go to DONE.
  - DONE: go to IDLE.
  - N = 4 if SEND_CRLF=1, else 2.
- Character map, by index:
  - 0: high nibble.
  - 1: low nibble.
  - 2: 13.
  - 3: 10.
- Nibble to ASCII: 0–9 → 48–57; 10–15 → 65–70 (uppercase 'A'–'F'). Computed on 4 bits with 8-bit output; no other codes are possible.
- `tx_data` updates on entry to SEND and holds through WAIT. In IDLE and DONE it holds its last value (0 after reset).
- Ignored inputs:
  - `start` outside IDLE, including the DONE cycle. It is not queued.
  - `tx_done` outside WAIT, including a `tx_done` in the same cycle as `tx_start`.
  - `data` changes after acceptance; they do not affect the transfer in progress.
- Reset mid-transfer aborts immediately. No further `tx_start` or `done_tick` is issued, and no character is resumed.

## Timing
- Reset values: state=IDLE, `tx_start`=0, `tx_data`=0, `busy`=0, `done_tick`=0, index=0, result register=0.
- Acceptance at edge k: SEND during cycle k..k+1, so `tx_start`=1 and `busy`=1 in the cycle after edge k.
- First `tx_start` appears exactly 1 cycle after `start` is sampled.
- `tx_done` sampled in WAIT at edge m: the next `tx_start` is high in the cycle after m (1-cycle gap). If it was the last character, `done_tick` is high in the cycle after m.
- DONE lasts exactly 1 cycle. IDLE follows, and a new `start` can be accepted at the next edge, i.e. 2 edges after the final `tx_done`.
- Minimum transfer with immediate `tx_done`: 2N+1 cycles from acceptance to the IDLE return.
- `tx_start` never asserts twice for the same character. Exactly N `tx_start` pulses per accepted `start`, with no reset between.

## Test plan
- SEND_CRLF=1, `data`=0x3C, `tx_done` 10 cycles after each `tx_start`: `tx_data` sequence 51, 67, 13, 10; 4 `tx_start` pulses; one `done_tick` 1 cycle after the 4th `tx_done`; `busy` 0 afterwards.
- SEND_CRLF=0, `data`=0xA0, then `data`=0x09: sequences 65, 48 and 48, 57; 2 `tx_start` pulses each.
- Hold `start`=1 throughout a 0xFF transfer and change `data` to 0x00 mid-transfer: sequence 70, 70, 13, 10 only. A second transfer starts only after DONE, i.e. the next `tx_start` comes 2 cycles after `done_tick`.
- Pulse `tx_done` in IDLE and in the cycle of `tx_start`: no state advance, no extra `tx_start`. `tx_data` stays at the first char until a `tx_done` arrives in WAIT.
- Assert `reset` in WAIT after the 2nd character of 0x5E: all outputs 0 immediately (asynchronous), no `done_tick`. A following `start` with 0x12 sends 49, 50, 13, 10 from index 0.
- Exhaustive sweep of `data` 0x00–0xFF with immediate `tx_done`: every hex char matches the nibble map, and each transfer takes 2N+1 cycles.
